// File: rtl/d_ip_regbus_pkg.sv
// Shared types for the register-bus initiator: FSM states, command layout, default widths.
// Optional feature macro: REGBUS_MASTER_RMW_EN (adds the read-modify-write state and fields).
package d_ip_regbus_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT
`ifdef REGBUS_MASTER_RMW_EN
        , ST_RMW_WR
`endif
    } state_e;

    // Command as offered on the stream at the default bus widths.
    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
`ifdef REGBUS_MASTER_RMW_EN
        logic                  rmw;
        logic [DEF_DATA_W-1:0] mask;
`endif
    } cmd_t;

endpackage

// File: rtl/d_ip_regbus_master_if.sv
// Command stream, response stream and timer slave bus of the register-bus initiator.
// Optional feature macro: REGBUS_MASTER_RMW_EN (adds cmd_rmw / cmd_mask).
interface d_ip_regbus_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
`ifdef REGBUS_MASTER_RMW_EN
    logic              cmd_rmw;
    logic [DATA_W-1:0] cmd_mask;
`endif

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;

    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              mod_en;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
`ifdef REGBUS_MASTER_RMW_EN
        input  cmd_rmw, cmd_mask,
`endif
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_addr,
        input  rsp_ready,
        output addr, wr_en, mod_en, wdata,
        input  rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
`ifdef REGBUS_MASTER_RMW_EN
        output cmd_rmw, cmd_mask,
`endif
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_addr,
        output rsp_ready,
        input  addr, wr_en, mod_en, wdata,
        output rdata
    );

endinterface

// File: rtl/d_ip_regbus_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit so full and empty are distinguishable.
module d_ip_regbus_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/d_ip_regbus_master.sv
// Register-bus initiator: queues read/write commands and plays them in order on the timer slave port.
// Optional feature macro: REGBUS_MASTER_RMW_EN (masked read-modify-write commands).
module d_ip_regbus_master
    import d_ip_regbus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    d_ip_regbus_master_if.master bus,
    output logic                 busy
);

`ifdef REGBUS_MASTER_RMW_EN
    localparam int ENT_W = 2 + ADDR_W + 2 * DATA_W;
`else
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
`endif
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    logic [ENT_W-1:0]  fifo_din, fifo_dout;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic              head_write, head_is_rmw;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        wait_q, wait_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              can_issue, slot_free, acc_cyc, wr_cyc;

`ifdef REGBUS_MASTER_RMW_EN
    logic              head_rmw;
    logic [DATA_W-1:0] head_mask;
    logic              rmw_q, rmw_d;
    logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
    logic [DATA_W-1:0] rmw_mask_q, rmw_mask_d;

    function automatic logic [DATA_W-1:0] merge_bits(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [DATA_W-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign fifo_din = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_rmw, bus.cmd_mask};
    assign {head_write, head_addr, head_wdata, head_rmw, head_mask} = fifo_dout;
    assign head_is_rmw = head_rmw;
`else
    assign fifo_din = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign {head_write, head_addr, head_wdata} = fifo_dout;
    assign head_is_rmw = 1'b0;
`endif

    assign fifo_push = bus.cmd_valid && !fifo_full;

    d_ip_regbus_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
`ifdef REGBUS_MASTER_RMW_EN
        rmw_d       = rmw_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_mask_d  = rmw_mask_q;
`endif
        can_issue   = 1'b0;
        fifo_pop    = 1'b0;
        slot_free   = !rsp_valid_q || bus.rsp_ready;

        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_WRITE: begin
                state_d   = ST_IDLE;
                can_issue = 1'b1;
            end
            ST_READ: begin
                state_d = ST_WAIT;
                wait_d  = WAIT_INIT;
            end
            ST_WAIT: begin
                if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
`ifdef REGBUS_MASTER_RMW_EN
                end else if (rmw_q) begin
                    wdata_d = merge_bits(bus.rdata, rmw_wdata_q, rmw_mask_q);
                    state_d = ST_RMW_WR;
`endif
                end else begin
                    // The sampled read now owns the response slot, so only writes may follow at once.
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.rdata;
                    rsp_addr_d  = addr_q;
                    slot_free   = 1'b0;
                    state_d     = ST_IDLE;
                    can_issue   = 1'b1;
                end
            end
`ifdef REGBUS_MASTER_RMW_EN
            ST_RMW_WR: begin
                state_d   = ST_IDLE;
                can_issue = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (can_issue && !fifo_empty && (head_write || head_is_rmw || slot_free)) begin
            fifo_pop = 1'b1;
            addr_d   = head_addr;
            if (head_write && !head_is_rmw) begin
                state_d = ST_WRITE;
                wdata_d = head_wdata;
            end else begin
                state_d = ST_READ;
            end
`ifdef REGBUS_MASTER_RMW_EN
            rmw_d       = head_is_rmw;
            rmw_wdata_d = head_wdata;
            rmw_mask_d  = head_mask;
`endif
        end
    end

    always_comb begin
        acc_cyc = 1'b0;
        wr_cyc  = 1'b0;
        case (state_q)
            ST_WRITE: begin
                acc_cyc = 1'b1;
                wr_cyc  = 1'b1;
            end
            ST_READ: acc_cyc = 1'b1;
`ifdef REGBUS_MASTER_RMW_EN
            ST_RMW_WR: begin
                acc_cyc = 1'b1;
                wr_cyc  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
`ifdef REGBUS_MASTER_RMW_EN
            rmw_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
`ifdef REGBUS_MASTER_RMW_EN
            rmw_q       <= rmw_d;
`endif
        end
    end

`ifdef REGBUS_MASTER_RMW_EN
    always_ff @(posedge clk) begin
        rmw_wdata_q <= rmw_wdata_d;
        rmw_mask_q  <= rmw_mask_d;
    end
`endif

    assign bus.cmd_ready = !fifo_full;
    assign bus.mod_en    = acc_cyc;
    assign bus.wr_en     = wr_cyc;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_d_ip_regbus_master.sv
// Directed bench for d_ip_regbus_master with a transaction-level scoreboard and a latency-2 slave model.
// Build with REGBUS_MASTER_RMW_EN defined to also exercise read-modify-write.
module tb_d_ip_regbus_master;
    import d_ip_regbus_pkg::*;

    localparam int RD_LAT = 2;

    typedef struct packed { logic wr; logic [5:0] addr; logic [7:0] data; } acc_t;
    typedef struct packed { logic [5:0] addr; logic [7:0] data; } rsp_t;

    logic clk = 1'b0;
    logic rst_b;
    logic busy;
    logic sim_init;

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    logic [7:0] pred_regs [64];
    logic [7:0] slave_regs [64];
    logic [7:0] rd_p0, rd_p1;

    always #5 clk = ~clk;

    d_ip_regbus_master_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    d_ip_regbus_master #(
        .ADDR_W     (6),
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus),
        .busy  (busy)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 2)  return 8'h3C;
        if (i == 16) return 8'hF0;
        return 8'(i) ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Timer slave: register file with a two-cycle read pipeline; junk outside the valid window.
    always @(posedge clk) begin
        if (sim_init) begin
            for (int i = 0; i < 64; i++) slave_regs[i] <= init_val(i);
        end else if (bus.mod_en && bus.wr_en) begin
            slave_regs[bus.addr] <= bus.wdata;
        end
        rd_p0 <= (bus.mod_en && !bus.wr_en) ? slave_regs[bus.addr] : 8'hEE;
        rd_p1 <= rd_p0;
    end
    assign bus.rdata = rd_p1;

    // Scoreboard: commands become expected accesses/responses in order when they are accepted.
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        logic [7:0] nv;
        if (sim_init) begin
            for (int i = 0; i < 64; i++) pred_regs[i] = init_val(i);
        end
        if (!rst_b) begin
            exp_acc.delete();
            exp_rsp.delete();
            chk("rst_mod_en", 32'(bus.mod_en), 0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        end else begin
            if (bus.mod_en) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access", 32'(bus.addr), 'hFFFF);
                end else begin
                    a = exp_acc.pop_front();
                    chk("acc_wr_en", 32'(bus.wr_en), 32'(a.wr));
                    chk("acc_addr", 32'(bus.addr), 32'(a.addr));
                    if (a.wr) chk("acc_wdata", 32'(bus.wdata), 32'(a.data));
                end
            end else begin
                chk("idle_wr_en", 32'(bus.wr_en), 0);
            end
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_addr), 'hFFFF);
                end else begin
                    r = exp_rsp[0];
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.data));
                    chk("rsp_addr", 32'(bus.rsp_addr), 32'(r.addr));
                    if (bus.rsp_ready) begin
                        void'(exp_rsp.pop_front());
                        rsp_count++;
                    end
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
`ifdef REGBUS_MASTER_RMW_EN
                if (bus.cmd_rmw) begin
                    nv = (pred_regs[bus.cmd_addr] & ~bus.cmd_mask) | (bus.cmd_wdata & bus.cmd_mask);
                    exp_acc.push_back('{1'b0, bus.cmd_addr, 8'h00});
                    exp_acc.push_back('{1'b1, bus.cmd_addr, nv});
                    pred_regs[bus.cmd_addr] = nv;
                end else
`endif
                if (bus.cmd_write) begin
                    exp_acc.push_back('{1'b1, bus.cmd_addr, bus.cmd_wdata});
                    pred_regs[bus.cmd_addr] = bus.cmd_wdata;
                end else begin
                    exp_acc.push_back('{1'b0, bus.cmd_addr, 8'h00});
                    exp_rsp.push_back('{bus.cmd_addr, pred_regs[bus.cmd_addr]});
                end
            end
        end
    end

    function automatic cmd_t mk(input logic w, input logic [5:0] a, input logic [7:0] d);
        cmd_t c;
        c       = '0;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    task automatic push(input cmd_t c);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = c.write;
        bus.cmd_addr  = c.addr;
        bus.cmd_wdata = c.wdata;
`ifdef REGBUS_MASTER_RMW_EN
        bus.cmd_rmw   = c.rmw;
        bus.cmd_mask  = c.mask;
`endif
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        if (n == 200) chk("push_timeout", 32'(n), 0);
        else begin
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy && !bus.rsp_valid && exp_acc.size() == 0) break;
        end
        chk("drain_timeout", 32'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, base;
        cmd_t c;
        rst_b         = 1'b0;
        sim_init      = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
`ifdef REGBUS_MASTER_RMW_EN
        bus.cmd_rmw   = 1'b0;
        bus.cmd_mask  = '0;
`endif
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 sim_init = 1'b0;
        #2 rst_b = 1'b1;
        step();

        chk("reset_mod_en", 32'(bus.mod_en), 0);
        chk("reset_wr_en", 32'(bus.wr_en), 0);
        chk("reset_addr", 32'(bus.addr), 0);
        chk("reset_wdata", 32'(bus.wdata), 0);
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("reset_rsp_addr", 32'(bus.rsp_addr), 0);
        chk("reset_busy", 32'(busy), 0);

        // Single write.
        push(mk(1'b1, 6'h05, 8'hA5));
        chk("wr_no_bypass", 32'(bus.mod_en), 0);
        step();
        chk("wr_mod_en", 32'(bus.mod_en), 1);
        chk("wr_wr_en", 32'(bus.wr_en), 1);
        chk("wr_addr", 32'(bus.addr), 'h05);
        chk("wr_wdata", 32'(bus.wdata), 'hA5);
        step();
        chk("wr_one_cycle", 32'(bus.mod_en), 0);
        chk("wr_addr_hold", 32'(bus.addr), 'h05);
        chk("wr_wdata_hold", 32'(bus.wdata), 'hA5);
        chk("wr_no_rsp", 32'(bus.rsp_valid), 0);
        chk("wr_idle_busy", 32'(busy), 0);

        // Single read, latency 2.
        push(mk(1'b0, 6'h02, 8'h00));
        step();
        chk("rd_mod_en", 32'(bus.mod_en), 1);
        chk("rd_wr_en", 32'(bus.wr_en), 0);
        chk("rd_addr", 32'(bus.addr), 'h02);
        step();
        chk("rd_t1_mod_en", 32'(bus.mod_en), 0);
        chk("rd_t1_rsp", 32'(bus.rsp_valid), 0);
        step();
        chk("rd_t2_rsp", 32'(bus.rsp_valid), 0);
        step();
        chk("rd_t3_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rd_t3_rdata", 32'(bus.rsp_rdata), 'h3C);
        chk("rd_t3_raddr", 32'(bus.rsp_addr), 'h02);
        step();
        chk("rd_consumed", 32'(bus.rsp_valid), 0);

        // Back-to-back writes.
        push(mk(1'b1, 6'h08, 8'h11));
        chk("b2b_c0", 32'(bus.mod_en), 0);
        push(mk(1'b1, 6'h09, 8'h22));
        chk("b2b_c1_en", 32'(bus.mod_en), 1);
        chk("b2b_c1_addr", 32'(bus.addr), 'h08);
        push(mk(1'b1, 6'h0A, 8'h33));
        chk("b2b_c2_addr", 32'(bus.addr), 'h09);
        step();
        chk("b2b_c3_en", 32'(bus.mod_en), 1);
        chk("b2b_c3_addr", 32'(bus.addr), 'h0A);
        chk("b2b_c3_wdata", 32'(bus.wdata), 'h33);
        step();
        chk("b2b_done", 32'(bus.mod_en), 0);

        // Response back-pressure with six reads.
        base = rsp_count;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk(1'b0, 6'(2 + i), 8'h00));
        chk("bp_full", 32'(bus.cmd_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        cnt = 0;
        repeat (5) begin
            step();
            if (bus.mod_en) cnt++;
        end
        chk("bp_no_issue", 32'(cnt), 0);
        chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
        chk("bp_hold_rdata", 32'(bus.rsp_rdata), 'h3C);
        chk("bp_hold_addr", 32'(bus.rsp_addr), 'h02);
        bus.rsp_ready = 1'b1;
        chk("full_pop_ready_low", 32'(bus.cmd_ready), 0);
        step();
        chk("full_pop_ready_rise", 32'(bus.cmd_ready), 1);
        push(mk(1'b0, 6'h07, 8'h00));
        wait_quiet(200);
        chk("bp_rsp_count", 32'(rsp_count - base), 6);

`ifdef REGBUS_MASTER_RMW_EN
        // Read-modify-write: 0xF0 with mask 0x0F and data 0x05 gives 0xF5.
        c       = mk(1'b1, 6'h10, 8'h05);
        c.rmw   = 1'b1;
        c.mask  = 8'h0F;
        push(c);
        chk("rmw_c0", 32'(bus.mod_en), 0);
        step();
        chk("rmw_rd_en", 32'(bus.mod_en), 1);
        chk("rmw_rd_wr_en", 32'(bus.wr_en), 0);
        chk("rmw_rd_addr", 32'(bus.addr), 'h10);
        step();
        chk("rmw_w1", 32'(bus.mod_en), 0);
        step();
        chk("rmw_w2", 32'(bus.mod_en), 0);
        step();
        chk("rmw_wr_en", 32'(bus.wr_en), 1);
        chk("rmw_wr_mod_en", 32'(bus.mod_en), 1);
        chk("rmw_wdata", 32'(bus.wdata), 'hF5);
        step();
        chk("rmw_done", 32'(bus.mod_en), 0);
        chk("rmw_no_rsp", 32'(bus.rsp_valid), 0);
        chk("rmw_idle", 32'(busy), 0);
`else
        c = mk(1'b0, 6'h00, 8'h00);
`endif

        // Reset while waiting for read data with two writes queued.
        push(mk(1'b0, 6'h03, 8'h00));
        push(mk(1'b1, 6'h30, 8'h77));
        push(mk(1'b1, 6'h31, 8'h78));
        chk("rst_pre_busy", 32'(busy), 1);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_mod_en", 32'(bus.mod_en), 0);
        chk("arst_wr_en", 32'(bus.wr_en), 0);
        chk("arst_addr", 32'(bus.addr), 0);
        chk("arst_wdata", 32'(bus.wdata), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
        repeat (2) @(posedge clk);
        #3 rst_b = 1'b1;
        cnt = 0;
        base = 0;
        repeat (8) begin
            step();
            if (bus.mod_en) cnt++;
            if (bus.rsp_valid) base++;
        end
        chk("post_rst_no_access", 32'(cnt), 0);
        chk("post_rst_no_rsp", 32'(base), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("sb_acc_empty", 32'(exp_acc.size()), 0);
        chk("sb_rsp_empty", 32'(exp_rsp.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_ip_regbus_master.md
# d_ip_regbus_master

Synthesizable register-bus initiator that drives the timer peripheral's 6-bit address / 8-bit data slave port (`addr`, `wr_en`, `mod_en`, `wdata`, `rdata`). It accepts read and write commands on a valid/ready stream, buffers them in a small FIFO and issues them in order as bus accesses. Read data returns on a valid/ready response stream. It sits between a system controller (CPU shim or sequencer) and one `d_ip_timer` instance.

## Interface
- `ADDR_W`, 6, bus address width
- `DATA_W`, 8, bus data width
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2
- `RD_LAT`, 1, cycles from the `mod_en` read cycle to valid `rdata`; legal range 1..4
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock
- `rst_b`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO not full
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target register
- `cmd_wdata`  in  DATA_W  write data
- `cmd_rmw`, `cmd_mask`  in  1 / DATA_W  present only with `REGBUS_MASTER_RMW_EN`
- `rsp_valid`  out  1  read response held
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  DATA_W  captured read data
- `rsp_addr`  out  ADDR_W  address of that read
- `addr`  out  ADDR_W  bus address
- `wr_en`  out  1  bus write strobe
- `mod_en`  out  1  bus access strobe
- `wdata`  out  DATA_W  bus write data
- `rdata`  in  DATA_W  bus read data
- `busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- A command is pushed on the edge where `cmd_valid && cmd_ready`. `cmd_ready = !full`, taken from registered state only. A push while full is ignored.
- FSM states:
  - IDLE: pop the FIFO head when non-empty. Write → WRITE. Read → READ if the response slot is free (`!rsp_valid`, or `rsp_ready` this cycle); otherwise stay in IDLE.
  - WRITE: one cycle with `mod_en=1`, `wr_en=1`, `addr`/`wdata` driven. Then → IDLE.
  - READ: one cycle with `mod_en=1`, `wr_en=0`. Then → WAIT.
  - WAIT: RD_LAT cycles; `addr` held and `mod_en=0`. `rdata` is sampled at the end of the last WAIT cycle into `rsp_rdata`/`rsp_addr`, and `rsp_valid` is set. Then → IDLE.
- Writes produce no response. Commands complete strictly in order.
- Outside an access cycle: `mod_en=0` and `wr_en=0`. `addr`/`wdata` hold their last values.
- `rsp_valid` clears on the edge where `rsp_valid && rsp_ready`.

## Timing
- Reset values: `addr=0`, `wdata=0`, `wr_en=0`, `mod_en=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_addr=0`, `busy=0`, `cmd_ready=1`. FIFO is emptied and the FSM goes to IDLE.
- Latency from push to bus cycle: push at edge N, access in cycle N+1 (no bypass).
- Write throughput: one write per cycle, back to back.
- Read: access cycle T, `rsp_valid=1` from cycle T+RD_LAT+1. The next command may issue in cycle T+RD_LAT+1.
- Empty FIFO: the FSM idles with strobes low. Full FIFO with a simultaneous pop: `cmd_ready` stays low that cycle and rises on the next cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously). In-flight and queued commands are discarded and no response is produced.

## Configuration
- `REGBUS_MASTER_RMW_EN`, defined:
  - Adds the `cmd_rmw` and `cmd_mask` ports and stores them in each FIFO entry.
  - An RMW command runs READ → WAIT, then a WRITE cycle immediately after the sample cycle.
  - The written value is `(rdata & ~cmd_mask) | (cmd_wdata & cmd_mask)`.
  - An RMW command generates no response and needs no free response slot.
- `REGBUS_MASTER_RMW_EN`, undefined: the ports are absent, the FIFO entry is narrower, and only plain read and write exist.

## Structure
- Package `d_ip_regbus_pkg`:
  - FSM state enum (IDLE, WRITE, READ, WAIT, plus RMW_WR under the macro)
  - command struct typedef
  - default `ADDR_W`/`DATA_W` constants
- Sub-module `d_ip_regbus_fifo`: synchronous FIFO with push/pop, full/empty and an asynchronous active-low reset.

## Test plan
- Reset release → `mod_en=0`, `wr_en=0`, `addr=0`, `cmd_ready=1`, `rsp_valid=0`, `busy=0`.
- Write to addr 0x05 with data 0xA5 → exactly one cycle of `mod_en=1`, `wr_en=1`, `addr=0x05`, `wdata=0xA5`; no response.
- RD_LAT=2; the bus model returns 0x3C for addr 0x02 → `mod_en` high one cycle with `wr_en=0`; `rsp_valid` rises 3 cycles after the access with `rsp_rdata=0x3C`, `rsp_addr=0x02`.
- `rsp_ready=0`, six reads pushed → first read completes and holds 0x3C; second read does not issue; `cmd_ready` falls once 4 entries are queued; setting `rsp_ready=1` drains everything in order.
- RMW build: register holds 0xF0; RMW with mask 0x0F, wdata 0x05 → read cycle, then a write cycle with `wdata=0xF5`; no response.
- `rst_b` pulled low during WAIT with 2 commands queued → strobes drop immediately; after release `busy=0`, `rsp_valid` stays 0 and no further bus cycles occur.
